pipe_stage_chain: RTL and testbench
===================================

Name: pipe_stage_chain

Overview:
- Parametrised elastic pipeline register chain for the CPU datapath; successor to the fixed single-select pipeline register plus NOP mux.
- Carries a WIDTH-bit control/data word through DEPTH stages with per-stage valid, downstream backpressure, per-stage flush, and bubble (NOP) insertion selected by nop_sel.
- Sits between decode and execute/memory stages.
- Bench style: 4 ns clock period, reset asserted at t=0 and released mid-cycle.

Parameters:
- WIDTH, 32, width of the carried word.
- DEPTH, 4, number of register stages (minimum 1).
- NOP_WORD, 0, WIDTH-bit value loaded into an empty or killed stage.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- in_valid  input  1  upstream word valid.
- in_data  input  WIDTH  upstream word.
- in_ready  output  1  stage 0 can accept this cycle.
- nop_sel  input  1  1 = inject bubble into stage 0 instead of in_data.
- flush  input  DEPTH  per-stage kill, bit i = stage i.
- out_valid  output  1  valid of stage DEPTH-1.
- out_data  output  WIDTH  data of stage DEPTH-1.
- out_ready  input  1  downstream accepts.
- occupancy  output  $clog2(DEPTH+1)  number of valid stages.
- stall_cnt  output  16  performance counter (see Optional Feature).

Behaviour:
- Reset (reset=0, asynchronous): all valid bits clear and all stage data set to NOP_WORD. Outputs: out_valid=0, out_data=NOP_WORD, occupancy=0, stall_cnt=0. Outputs depend only on registers, except in_ready.
- Stage advance: ready[DEPTH-1] = !valid[DEPTH-1] | out_ready; ready[i] = !valid[i] | ready[i+1]. These are combinational bubble-collapsing signals. When ready[i]=1, stage i loads from stage i-1 (stage 0 loads from the input).
- If ready[i]=0, stage i holds its data and valid.
- in_ready = ready[0] & !nop_sel.
- Input accept: an input transfer occurs when in_valid & in_ready.
- Stage 0 load when ready[0]=1:
  - nop_sel=1: data=NOP_WORD, valid=0, and in_data is not consumed.
  - nop_sel=0: data=in_data, valid=in_valid.
- Latency: a word accepted at edge k appears on out_data after edge k+DEPTH-1, i.e. DEPTH cycles input-to-output register latency with no stall. Throughput is 1 word/cycle.
- Flush: flush[i]=1 forces valid[i]=0 and data[i]=NOP_WORD after the edge, whatever would have loaded. A word leaving stage i in the same cycle still moves into stage i+1 unless flush[i+1] is also set.
- flush does not change the ready computation of that cycle.
- Full chain with out_ready=0: all stages hold, in_ready=0, input not consumed.
- Simultaneous accept at input and output with a full chain: all stages shift, occupancy unchanged.
- occupancy equals the popcount of the valid bits, registered-consistent (derived from the current valid vector).
- Reset asserted mid-operation: all in-flight words are lost immediately; no partial state is retained.
- The first rising edge after reset deassertion behaves as a normal cycle.

Optional Feature:
- Macro PIPE_PERF_CNT_EN.
- Defined: stall_cnt increments by 1 on each edge where out_valid=1 and out_ready=0. It saturates at 16'hFFFF and is cleared by reset only.
- Not defined: stall_cnt is tied to 16'h0000 and no counter flops are built. The port list is identical in both builds.

Test Plan:
- Reset held 0 for 3 ns, released; in_valid=1, in_data=32'h11,22,33,44 on consecutive cycles, out_ready=1, DEPTH=4 -> out_data=32'h11 with out_valid=1 on the 4th edge after the first accept, then 22,33,44 back-to-back; occupancy peaks at 4.
- Fill all 4 stages, out_ready=0 for 3 cycles -> in_ready=0, out_data held at first word, occupancy=4; with PIPE_PERF_CNT_EN, stall_cnt=3. Then out_ready=1 -> words drain in order with no loss or duplication.
- nop_sel=1 for 2 cycles during streaming (mirrors S toggling at t=40) -> in_ready=0, two bubbles (out_valid=0, out_data=NOP_WORD) appear at the output 4 cycles later, and no input word is dropped.
- Full chain, flush=4'b0100 for one cycle with out_ready=1 -> the word from stage 1 is killed; the output shows valid, valid, bubble, valid; occupancy drops by 1.
- Stream in progress, reset driven 0 asynchronously between edges -> out_valid=0, occupancy=0, out_data=NOP_WORD immediately, before the next clk edge.
- Build without PIPE_PERF_CNT_EN, repeat the stall scenario -> stall_cnt stays 16'h0000.

Source files
------------

// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: elastic DEPTH-stage register chain with bubble collapse, per-stage flush and NOP injection.
// Defining PIPE_PERF_CNT_EN builds the saturating output-stall counter behind stall_cnt.
module pipe_stage_chain #(
    parameter int               WIDTH    = 32,
    parameter int               DEPTH    = 4,
    parameter logic [WIDTH-1:0] NOP_WORD = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       in_ready,
    input  logic                       nop_sel,
    input  logic [DEPTH-1:0]           flush,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic [15:0]                stall_cnt
);
    localparam int OCC_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_data     [DEPTH];
    logic [DEPTH-1:0] r_vld;
    logic [WIDTH-1:0] w_nxt_data [DEPTH];
    logic [DEPTH-1:0] w_nxt_vld;
    logic [DEPTH-1:0] w_ready;
    logic             w_hole;
    logic [OCC_W-1:0] w_occ;

    // A stage can advance when any stage at or below it is empty, or the sink takes the head word.
    always_comb begin
        w_ready = '0;
        w_hole  = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            w_hole     = w_hole | ~r_vld[i];
            w_ready[i] = w_hole;
        end
    end

    assign in_ready = w_ready[0] & ~nop_sel;

    always_comb begin
        w_nxt_data = r_data;
        w_nxt_vld  = r_vld;
        if (w_ready[0]) begin
            if (nop_sel) begin
                w_nxt_data[0] = NOP_WORD;
                w_nxt_vld[0]  = 1'b0;
            end else begin
                w_nxt_data[0] = in_data;
                w_nxt_vld[0]  = in_valid;
            end
        end
        for (int i = 1; i < DEPTH; i++) begin
            if (w_ready[i]) begin
                w_nxt_data[i] = r_data[i-1];
                w_nxt_vld[i]  = r_vld[i-1];
            end
        end
        // Flush overrides whatever would have loaded; it never feeds back into ready.
        for (int i = 0; i < DEPTH; i++) begin
            if (flush[i]) begin
                w_nxt_data[i] = NOP_WORD;
                w_nxt_vld[i]  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_vld <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= NOP_WORD;
            end
        end else begin
            r_vld  <= w_nxt_vld;
            r_data <= w_nxt_data;
        end
    end

    always_comb begin
        w_occ = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_occ = w_occ + OCC_W'(r_vld[i]);
        end
    end

    assign occupancy = w_occ;
    assign out_valid = r_vld[DEPTH-1];
    assign out_data  = r_data[DEPTH-1];

`ifdef PIPE_PERF_CNT_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= 16'h0000;
        end else if (out_valid && !out_ready) begin
            r_stall_cnt <= sat_inc16(r_stall_cnt);
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed bench for pipe_stage_chain (DEPTH=4, WIDTH=32, NOP_WORD=0), 4 ns clock.
`timescale 1ns/1ps
module tb_pipe_stage_chain;
    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        nop_sel;
    logic [3:0]  flush;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
    logic [2:0]  occupancy;
    logic [15:0] stall_cnt;

    int n_chk  = 0;
    int n_fail = 0;

`ifdef PIPE_PERF_CNT_EN
    localparam logic [15:0] EXP_STALL = 16'd3;
`else
    localparam logic [15:0] EXP_STALL = 16'd0;
`endif

    pipe_stage_chain dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .nop_sel   (nop_sel),
        .flush     (flush),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #2 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic ns);
        in_valid = v;
        in_data  = d;
        nop_sel  = ns;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [31:0] d);
        check_eq({tag, "_vld"}, 32'(out_valid), 32'(v));
        check_eq({tag, "_data"}, out_data, d);
    endtask

    // nop_sel scenario tables, one entry per cycle
    logic        s3_v   [10] = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 0};
    logic [31:0] s3_d   [10] = '{32'hB1, 32'hB2, 32'hB3, 32'hB3, 32'hB3, 32'hB4, 0, 0, 0, 0};
    logic        s3_ns  [10] = '{0, 0, 1, 1, 0, 0, 0, 0, 0, 0};
    logic        s3_rdy [10] = '{1, 1, 0, 0, 1, 1, 1, 1, 1, 1};
    logic        s3_ov  [10] = '{0, 0, 0, 1, 1, 0, 0, 1, 1, 0};
    logic [31:0] s3_od  [10] = '{0, 0, 0, 32'hB1, 32'hB2, 0, 0, 32'hB3, 32'hB4, 0};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; flush = 4'b0000; out_ready = 1'b1;
        drive(1'b0, 32'h0, 1'b0);
        #1;
        check_out("rst", 1'b0, 32'h0);
        check_eq("rst_occ", 32'(occupancy), 0);
        check_eq("rst_stall", 32'(stall_cnt), 0);
        #2 reset = 1'b1;

        // streaming 11,22,33,44
        drive(1'b1, 32'h11, 1'b0); cyc();
        check_eq("s1_occ1", 32'(occupancy), 1);
        check_eq("s1_out_empty", 32'(out_valid), 0);
        drive(1'b1, 32'h22, 1'b0); cyc();
        drive(1'b1, 32'h33, 1'b0); cyc();
        check_eq("s1_occ3", 32'(occupancy), 3);
        drive(1'b1, 32'h44, 1'b0); cyc();
        check_out("s1_w11", 1'b1, 32'h11);
        check_eq("s1_occ4", 32'(occupancy), 4);
        drive(1'b0, 32'h0, 1'b0); cyc();
        check_out("s1_w22", 1'b1, 32'h22);
        check_eq("s1_occ_d3", 32'(occupancy), 3);
        cyc(); check_out("s1_w33", 1'b1, 32'h33);
        cyc(); check_out("s1_w44", 1'b1, 32'h44);
        cyc(); check_out("s1_empty", 1'b0, 32'h0);
        check_eq("s1_occ0", 32'(occupancy), 0);

        // fill with sink stalled, hold for three cycles, then drain
        out_ready = 1'b0;
        drive(1'b1, 32'hA1, 1'b0); cyc();
        drive(1'b1, 32'hA2, 1'b0); cyc();
        drive(1'b1, 32'hA3, 1'b0); cyc();
        drive(1'b1, 32'hA4, 1'b0); cyc();
        check_out("s2_full", 1'b1, 32'hA1);
        check_eq("s2_stall0", 32'(stall_cnt), 0);
        drive(1'b1, 32'hA5, 1'b0);
        #1 check_eq("s2_inrdy_full", 32'(in_ready), 0);
        for (int k = 0; k < 3; k++) begin
            cyc();
            check_out("s2_hold", 1'b1, 32'hA1);
            check_eq("s2_hold_occ", 32'(occupancy), 4);
            check_eq("s2_hold_inrdy", 32'(in_ready), 0);
        end
        check_eq("s2_stall3", 32'(stall_cnt), 32'(EXP_STALL));
        out_ready = 1'b1;
        #1 check_eq("s2_inrdy_go", 32'(in_ready), 1);
        cyc();
        check_out("s2_wA2", 1'b1, 32'hA2);
        check_eq("s2_occ_shift", 32'(occupancy), 4);
        drive(1'b0, 32'h0, 1'b0);
        cyc(); check_out("s2_wA3", 1'b1, 32'hA3);
        cyc(); check_out("s2_wA4", 1'b1, 32'hA4);
        cyc(); check_out("s2_wA5", 1'b1, 32'hA5);
        cyc(); check_out("s2_empty", 1'b0, 32'h0);
        check_eq("s2_stall_kept", 32'(stall_cnt), 32'(EXP_STALL));

        // two-cycle bubble injection during streaming
        for (int n = 0; n < 10; n++) begin
            drive(s3_v[n], s3_d[n], s3_ns[n]);
            #1 check_eq($sformatf("s3_inrdy%0d", n), 32'(in_ready), 32'(s3_rdy[n]));
            cyc();
            check_out($sformatf("s3_out%0d", n), s3_ov[n], s3_od[n]);
        end

        // full chain, flush stage 2 for one cycle with sink accepting
        drive(1'b1, 32'hC1, 1'b0); cyc();
        drive(1'b1, 32'hC2, 1'b0); cyc();
        drive(1'b1, 32'hC3, 1'b0); cyc();
        drive(1'b1, 32'hC4, 1'b0); cyc();
        check_out("s4_wC1", 1'b1, 32'hC1);
        drive(1'b1, 32'hC5, 1'b0); flush = 4'b0100; cyc();
        flush = 4'b0000;
        check_out("s4_wC2", 1'b1, 32'hC2);
        check_eq("s4_occ_drop", 32'(occupancy), 3);
        drive(1'b1, 32'hC6, 1'b0); cyc();
        check_out("s4_bubble", 1'b0, 32'h0);
        drive(1'b0, 32'h0, 1'b0); cyc();
        check_out("s4_wC4", 1'b1, 32'hC4);
        cyc(); check_out("s4_wC5", 1'b1, 32'hC5);
        cyc(); check_out("s4_wC6", 1'b1, 32'hC6);
        cyc(); check_out("s4_empty", 1'b0, 32'h0);

        // asynchronous reset while the chain is full
        drive(1'b1, 32'hD1, 1'b0); cyc();
        drive(1'b1, 32'hD2, 1'b0); cyc();
        drive(1'b1, 32'hD3, 1'b0); cyc();
        out_ready = 1'b0;
        drive(1'b1, 32'hD4, 1'b0); cyc();
        cyc();
        check_eq("s5_pre_occ", 32'(occupancy), 4);
        check_out("s5_pre", 1'b1, 32'hD1);
        #1 reset = 1'b0;
        #1;
        check_out("s5_async", 1'b0, 32'h0);
        check_eq("s5_async_occ", 32'(occupancy), 0);
        check_eq("s5_async_stall", 32'(stall_cnt), 0);
        cyc();
        #1 reset = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 32'hE1, 1'b0); cyc();
        check_eq("s5_first_edge_occ", 32'(occupancy), 1);
        drive(1'b0, 32'h0, 1'b0); cyc(); cyc(); cyc();
        check_out("s5_wE1", 1'b1, 32'hE1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
